// File: rtl/fetch_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue_if
//   Bundles the instruction-memory request/response path and the decode-facing
//   instruction stream of the fetch stage.
//
//   master : the fetch stage (drives memory requests and the instruction stream)
//   slave  : the environment (instruction memory + decode stage)
//
//   imem_req / imem_addr   fetch request and its word address
//   imem_rdata             read data, valid one cycle after a request
//   redirect / _target     decode-stage branch redirect and new fetch PC
//   stall                  decode not accepting this cycle
//   instr_out / pc_out     FIFO head (zero when empty)
//   instr_valid            FIFO non-empty
//   occupancy              FIFO entry count
// -----------------------------------------------------------------------------
interface fetch_prefetch_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_target;
  logic              stall;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] pc_out;
  logic              instr_valid;
  logic [CNT_W-1:0]  occupancy;

  modport master (
    output imem_req, imem_addr, instr_out, pc_out, instr_valid, occupancy,
    input  imem_rdata, redirect, redirect_target, stall
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, pc_out, instr_valid, occupancy,
    output imem_rdata, redirect, redirect_target, stall
  );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
//   Fetch stage sitting in front of the decode pipeline register. Owns the
//   word-addressed fetch PC, issues at most one read per cycle to a synchronous
//   instruction memory, and buffers returned {instruction, PC} pairs in a small
//   FIFO so decode sees a steady stream across stalls. A redirect flushes the
//   FIFO, drops any in-flight word and restarts fetch at the target.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset, highest priority
//     bus  - fetch_prefetch_queue_if.master (memory request path + decode side)
// -----------------------------------------------------------------------------
module fetch_prefetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  fetch_prefetch_queue_if.master        bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [DEPTH];

  logic              issue_s;
  logic              fill_s;
  logic              deq_s;
  logic              nonempty_s;
  logic [CNT_W:0]    pending_s;

  // Issue decision: buffered plus in-flight entries must leave a free slot.
  // The registered count is used without crediting this cycle's dequeue.
  always_comb begin
    pending_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    if (!rst && !bus.redirect && (pending_s < DEPTH_C)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fill/dequeue qualifiers; a redirect drops the word returning this cycle.
  always_comb begin
    nonempty_s = (count_q != {CNT_W{1'b0}});
    fill_s     = inflight_q && !bus.redirect && !rst;
    deq_s      = nonempty_s && !bus.stall && !bus.redirect && !rst;
  end

  // Next-state computation for PC, in-flight tracking, pointers and count.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue_s;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (bus.redirect) begin
      pc_d     = bus.redirect_target;
      rd_ptr_d = {PTR_W{1'b0}};
      wr_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      if (issue_s) begin
        pc_d          = pc_q + ADDR_W'(1'b1);
        inflight_pc_d = pc_q;
      end else begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
      end
      if (fill_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({fill_s, deq_s})
        2'b10:   count_d = count_q + CNT_W'(1'b1);
        2'b01:   count_d = count_q - CNT_W'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= {ADDR_W{1'b0}};
      inflight_q    <= 1'b0;
      inflight_pc_q <= {ADDR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      wr_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= {CNT_W{1'b0}};
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage; contents need no reset because empty entries are never shown.
  always_ff @(posedge clk) begin
    if (fill_s) begin
      data_mem_q[wr_ptr_q] <= bus.imem_rdata;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end else begin
      data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
      pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
    end
  end

  // Output drive: head entry when non-empty, NOP/zero PC otherwise.
  always_comb begin
    bus.imem_req    = issue_s;
    bus.imem_addr   = pc_q;
    bus.instr_valid = nonempty_s;
    bus.occupancy   = count_q;
    if (nonempty_s) begin
      bus.instr_out = data_mem_q[rd_ptr_q];
      bus.pc_out    = pc_mem_q[rd_ptr_q];
    end else begin
      bus.instr_out = {DATA_W{1'b0}};
      bus.pc_out    = {ADDR_W{1'b0}};
    end
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
Fetch stage placed directly upstream of the decode pipeline register. Owns the word-addressed program counter and issues one read per cycle to the synchronous instruction memory. Returned words, tagged with their PC, are buffered in a small FIFO so decode sees a steady instruction stream across decode stalls. A decode-stage branch redirect discards the buffered stream and refetches from the target.

Parameters:
DEPTH, 4, FIFO entries (power of two, >= 2; full throughput requires >= 3)
ADDR_W, 32, PC/address width (word address)
DATA_W, 32, instruction width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  ADDR_W  word address of request (= fetch PC)
imem_rdata  input  DATA_W  read data, valid exactly 1 cycle after the imem_req cycle
redirect  input  1  decode-stage branch taken; flush and refetch
redirect_target  input  ADDR_W  new fetch PC, sampled when redirect=1
stall  input  1  decode not accepting this cycle
instr_out  output  DATA_W  instruction at FIFO head; 0 (NOP) when empty
pc_out  output  ADDR_W  PC of instr_out; 0 when empty
instr_valid  output  1  FIFO non-empty
occupancy  output  $clog2(DEPTH)+1  FIFO entry count

Behaviour:
- Reset (rst=1 at an edge): fetch PC=0, FIFO empty (rd/wr pointers 0, count 0), in-flight flag 0. Outputs after reset: imem_req 0 during reset cycle, instr_valid 0, instr_out 0, pc_out 0, occupancy 0. rst has priority over every other input.
- Fetch PC increments by 1 per issued request (word addressing); wraps modulo 2^ADDR_W without error.
- Issue rule (combinational): imem_req = !rst && !redirect && (count + inflight < DEPTH). count is the registered value before this cycle's dequeue (conservative; no same-cycle credit). imem_addr = fetch PC, driven also when imem_req=0.
- In-flight tracking: inflight <= imem_req each edge. Its captured PC is held in a register alongside.
- Fill: cycle after a request (inflight=1, no redirect) writes {imem_rdata, inflight PC} at wr pointer at end of that cycle. Entry is visible on outputs the following cycle. Latency: request in cycle N -> instr_valid with that word in cycle N+2.
- Dequeue: when instr_valid && !stall, rd pointer advances at the edge. Simultaneous fill and dequeue leaves count unchanged. Pointers wrap modulo DEPTH.
- Overflow is impossible by the issue rule. An assertion in the bench checks count <= DEPTH. A dequeue attempt on empty FIFO is ignored.
- Redirect (redirect=1 in cycle R, overrides stall):
  - At edge R: FIFO cleared, fetch PC <= redirect_target, inflight <= 0.
  - Any imem_rdata arriving in cycle R is dropped.
  - No request in cycle R.
  - Cycle R+1: imem_req=1, imem_addr=target.
  - Cycle R+3: instr_valid=1, pc_out=target.
  - Outputs during R still show the old head; consumers must ignore them, since decode is flushing.
- Back-to-back redirects: each restarts the sequence; the last one wins.
- Steady state, no stall: one instruction per cycle, occupancy settles at 1.
- Stall held: FIFO fills to DEPTH, then imem_req drops to 0. On stall release, issue resumes the same cycle count+inflight < DEPTH holds.

Test Plan:
- Reset then free-run, imem word = address+0x100, stall=0 -> instr_valid first high cycle 3 after reset release with pc_out 0, instr_out 0x100; then pc_out 1,2,3… one per cycle, no gaps.
- Hold stall=1 from first valid for 10 cycles, DEPTH=4 -> occupancy reaches 4, imem_req 0 after 4th fill, head stays pc 0. Release -> pc 0,1,2,3,4,… consecutive with no loss or duplicate.
- Redirect with redirect_target=0x40 in cycle R while 3 entries are queued and one request is in flight -> occupancy 0 at R+1, imem_addr 0x40 at R+1, pc_out 0x40 valid at R+3, then 0x41. Stale in-flight word never appears.
- Redirect and stall asserted together, plus redirect again in R+1 with target 0x80 -> first valid pc_out is 0x80 at R+4. No 0x40 entry is ever enqueued.
- Fetch PC at 0xFFFFFFFE, free-run -> pc_out sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- rst asserted mid-stream with 2 entries queued and stall=1 -> next cycle instr_valid 0, occupancy 0, instr_out 0. After release, fetch resumes at pc 0.
